mux_4_1_rr_arbiter: RTL and testbench

- Shares one 4:1 select datapath between four independent requesters.
- Picks one valid requester per cycle with a rotating (round-robin) priority and drives the select internally.
- Captures the chosen word into a single-entry output register with a valid/ready handshake.
- Sits between four producer ports and one consumer; sustains one transfer per cycle when the consumer is ready.

---
 rtl/mux_4_1_rr_arbiter.sv | 123 ++++++++++++
 tb/tb_mux_4_1_rr_arbiter.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/mux_4_1_rr_arbiter.sv
// Four-requester arbiter sharing one 4:1 select path into a single-entry valid/ready output register.
// Define MUX_ARB_FIXED_PRIO_EN for fixed priority (requester 0 highest); default is round-robin.
module mux_4_1_rr_arbiter #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   in_valid,
    input  logic [W-1:0] in_data0,
    input  logic [W-1:0] in_data1,
    input  logic [W-1:0] in_data2,
    input  logic [W-1:0] in_data3,
    output logic [3:0]   in_ready,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic [1:0]   out_sel
);

    typedef enum logic {StEmpty, StFull} state_e;

    state_e         state_q, state_d;
    logic [W-1:0]   out_data_q, out_data_d;
    logic [1:0]     out_sel_q, out_sel_d;
    logic [1:0]     ptr;
    logic [1:0]     gnt;
    logic [1:0]     scan_idx;
    logic [W-1:0]   gnt_data;
    logic           can_load;
    logic           accept;

`ifdef MUX_ARB_FIXED_PRIO_EN
    assign ptr = 2'd0;
`else
    logic [1:0] ptr_q, ptr_d;

    assign ptr   = ptr_q;
    assign ptr_d = accept ? gnt + 2'd1 : ptr_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr_q <= 2'd0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    // Scan from the far end so the requester closest to ptr overwrites last and wins.
    always_comb begin
        gnt      = ptr;
        scan_idx = ptr;
        for (int k = 3; k >= 0; k--) begin
            scan_idx = ptr + k[1:0];
            if (in_valid[scan_idx]) begin
                gnt = scan_idx;
            end
        end
    end

    always_comb begin
        unique case (gnt)
            2'd0:    gnt_data = in_data0;
            2'd1:    gnt_data = in_data1;
            2'd2:    gnt_data = in_data2;
            default: gnt_data = in_data3;
        endcase
    end

    assign can_load = (state_q == StEmpty) | out_ready;
    assign accept   = rst & (|in_valid) & can_load;

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= StEmpty;
            out_data_q <= '0;
            out_sel_q  <= 2'd0;
        end else begin
            state_q    <= state_d;
            out_data_q <= out_data_d;
            out_sel_q  <= out_sel_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        out_data_d = out_data_q;
        out_sel_d  = out_sel_q;
        unique case (state_q)
            StEmpty: begin
                if (accept) begin
                    state_d = StFull;
                end
            end
            StFull: begin
                if (accept) begin
                    state_d = StFull;
                end else if (out_ready) begin
                    state_d = StEmpty;
                end
            end
            default: state_d = StEmpty;
        endcase
        if (accept) begin
            out_data_d = gnt_data;
            out_sel_d  = gnt;
        end
    end

    // Outputs
    always_comb begin
        in_ready = 4'b0000;
        if (accept) begin
            in_ready[gnt] = 1'b1;
        end
        out_valid = (state_q == StFull);
        out_data  = out_data_q;
        out_sel   = out_sel_q;
    end

endmodule

// File: tb/tb_mux_4_1_rr_arbiter.sv
// Randomised and directed bench for mux_4_1_rr_arbiter against a behavioural arbitration model.
// Honours MUX_ARB_FIXED_PRIO_EN the same way the design does.
module tb_mux_4_1_rr_arbiter;

    localparam int unsigned W = 4;

    logic         clk;
    logic         rst;
    logic [3:0]   in_valid;
    logic [W-1:0] in_data [4];
    logic [3:0]   in_ready;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic [1:0]   out_sel;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    int m_ptr   = 0;
    int m_valid = 0;
    int m_data  = 0;
    int m_sel   = 0;
    int acc_idx = -1;

    mux_4_1_rr_arbiter #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data0  (in_data[0]),
        .in_data1  (in_data[1]),
        .in_data2  (in_data[2]),
        .in_data3  (in_data[3]),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sel   (out_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // First requester with valid set, scanning ptr, ptr+1, ... mod 4; -1 if none.
    function automatic int model_gnt();
        int start;
`ifdef MUX_ARB_FIXED_PRIO_EN
        start = 0;
`else
        start = m_ptr;
`endif
        for (int k = 0; k < 4; k++) begin
            if (in_valid[(start + k) % 4]) return (start + k) % 4;
        end
        return -1;
    endfunction

    // One clock: check in_ready at negedge, advance model at posedge, check registers after.
    task automatic step();
        int  g;
        bit  can_load;
        logic [3:0] exp_rdy;
        @(negedge clk);
        g        = model_gnt();
        can_load = (m_valid == 0) || out_ready;
        exp_rdy  = 4'b0000;
        acc_idx  = -1;
        if (rst && g >= 0 && can_load) begin
            exp_rdy[g] = 1'b1;
            acc_idx    = g;
        end
        check("in_ready", 32'(in_ready), 32'(exp_rdy));
        @(posedge clk);
        if (!rst) begin
            m_ptr = 0; m_valid = 0; m_data = 0; m_sel = 0;
        end else if (acc_idx >= 0) begin
            m_data  = int'(in_data[acc_idx]);
            m_sel   = acc_idx;
            m_valid = 1;
            m_ptr   = (acc_idx + 1) % 4;
        end else if (m_valid != 0 && out_ready) begin
            m_valid = 0;
        end
        #1;
        check("out_valid", 32'(out_valid), 32'(m_valid));
        check("out_data", 32'(out_data), 32'(m_data));
        check("out_sel", 32'(out_sel), 32'(m_sel));
    endtask

    int rr_sel  [5] = '{0, 1, 2, 3, 0};
    int rr_data [5] = '{1, 2, 3, 4, 1};

    initial begin
        rst       = 1'b0;
        in_valid  = 4'hF;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) in_data[i] = W'(i + 1);

        // Reset held with all requesters active
        step();
        step();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);

        // Round-robin sweep
        rst       = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
`ifdef MUX_ARB_FIXED_PRIO_EN
            check("fixed_sel", 32'(out_sel), 32'd0);
            check("fixed_data", 32'(out_data), 32'd1);
`else
            check("rr_sel", 32'(out_sel), 32'(rr_sel[c]));
            check("rr_data", 32'(out_data), 32'(rr_data[c]));
`endif
        end

        // Backpressure: word A from requester 2 held while requester 0 waits
        in_valid   = 4'b0100;
        in_data[2] = 4'hA;
        step();
        check("bp_load_data", 32'(out_data), 32'hA);
        in_valid   = 4'b0001;
        in_data[0] = 4'h5;
        out_ready  = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            check("bp_hold_data", 32'(out_data), 32'hA);
            check("bp_hold_sel", 32'(out_sel), 32'd2);
            check("bp_hold_rdy", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        step();
        check("bp_next_data", 32'(out_data), 32'h5);
        check("bp_next_sel", 32'(out_sel), 32'd0);

        // Wrap/skip: grant 2 leaves ptr at 3, then 0 and 1 are served, leaving ptr at 2
        in_valid = 4'b0100;
        step();
        in_valid = 4'b0011;
        step();
        check("wrap_first", 32'(out_sel), 32'd0);
        step();
`ifndef MUX_ARB_FIXED_PRIO_EN
        check("wrap_second", 32'(out_sel), 32'd1);
        in_valid = 4'hF;
        step();
        check("wrap_ptr2", 32'(out_sel), 32'd2);
`endif

        // Drain to empty
        in_valid = 4'b0000;
        step();
        check("drain_valid", 32'(out_valid), 32'd0);
        check("drain_keep", 32'(out_data), 32'(m_data));

        // Randomised, protocol-compliant traffic
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_idx == i) begin
                    in_valid[i] = 1'($urandom_range(0, 1));
                    in_data[i]  = W'($urandom);
                end else if (!in_valid[i] && $urandom_range(0, 2) == 0) begin
                    in_valid[i] = 1'b1;
                    in_data[i]  = W'($urandom);
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 60) != 0);
            if (!rst) in_valid = in_valid; // requesters keep offering across reset
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
